// File: rtl/codec_init_pkg.sv
// Shared types and defaults for the codec init controller.
// Build option: CODEC_INIT_NACK_CHECK_EN enables I2C NACK counting/qualification.
// Holds the 3-bit state encoding and counter width helper.
package codec_init_pkg;

    typedef enum logic [2:0] {
        S_POWERUP = 3'd0,
        S_START   = 3'd1,
        S_WAIT    = 3'd2,
        S_RETRY   = 3'd3,
        S_READY   = 3'd4,
        S_FAIL    = 3'd5
    } state_e;

    localparam int unsigned DEF_POWERUP_CYCLES = 1000;
    localparam int unsigned DEF_TIMEOUT_CYCLES = 200000;
    localparam int unsigned DEF_MAX_RETRY      = 3;

    localparam logic [7:0] NACK_CNT_MAX = 8'hFF;

    // Bits needed to count 0..n-1, never narrower than one bit.
    function automatic int unsigned cnt_w(input int unsigned n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/i2c_ack_monitor.sv
// Flags a NACK: rising SCLK while the initializer releases SDA and SDA reads high.
// Latency: pulse is combinational on the cycle the SCLK rise is seen (one cycle wide).
// Backpressure: none; passive bus observer.
module i2c_ack_monitor (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_sclk,
    input  logic i_sdat,
    input  logic i_oen,
    output logic o_nack
);

    logic sclk_q;
    logic sclk_d;

    // Previous SCLK sample for edge detection.
    always_comb begin
        sclk_d = i_sclk;
    end

    // SCLK history register.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            sclk_q <= 1'b0;
        end else begin
            sclk_q <= sclk_d;
        end
    end

    // Rising SCLK, slave owns SDA (oen low) and SDA left high -> NACK.
    assign o_nack = ~sclk_q & i_sclk & ~i_oen & i_sdat;

endmodule

// File: rtl/codec_init_ctrl.sv
// Sequences codec init: power-up wait, start pulse, wait for done with timeout, retries.
// Latency: outputs registered, aligned with the state they describe; start is 1 cycle.
// Backpressure: none; i_reinit only honoured in READY/FAIL. Option: CODEC_INIT_NACK_CHECK_EN.
module codec_init_ctrl
    import codec_init_pkg::*;
#(
    parameter int unsigned POWERUP_CYCLES = DEF_POWERUP_CYCLES,
    parameter int unsigned TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
    parameter int unsigned MAX_RETRY      = DEF_MAX_RETRY
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_reinit,
    input  logic       i_init_finished,
    input  logic       i_sclk,
    input  logic       i_sdat,
    input  logic       i_oen,
    output logic       o_init_start,
    output logic       o_init_rst_n,
    output logic       o_ready,
    output logic       o_error,
    output logic [7:0] o_nack_cnt,
    output logic [2:0] o_state
);

    localparam int unsigned PW    = cnt_w(POWERUP_CYCLES);
    localparam int unsigned TW    = cnt_w(TIMEOUT_CYCLES);
    localparam int unsigned RW_C  = cnt_w(MAX_RETRY + 1);
    localparam int unsigned RW    = (RW_C < 2) ? 2 : RW_C;

    localparam logic [PW-1:0] PWR_LAST  = PW'(POWERUP_CYCLES - 1);
    localparam logic [PW-1:0] PWR_ONE   = PW'(1);
    localparam logic [TW-1:0] TMR_LAST  = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [TW-1:0] TMR_ONE   = TW'(1);
    localparam logic [RW-1:0] RETRY_MAX = RW'(MAX_RETRY);
    localparam logic [RW-1:0] RETRY_ONE = RW'(1);

    state_e        state_q, state_d;
    logic [PW-1:0] pwr_cnt_q, pwr_cnt_d;
    logic [TW-1:0] timer_q, timer_d;
    logic [RW-1:0] retry_cnt_q, retry_cnt_d;
    logic          rst_ph_q, rst_ph_d;      // second cycle of the initializer reset
    logic          fin_q, fin_d;
    logic          start_q, start_d;
    logic          init_rst_n_q, init_rst_n_d;
    logic          ready_q, ready_d;
    logic          error_q, error_d;
    logic [7:0]    nack_cnt_q, nack_cnt_d;
    logic          fin_rise;
    logic          attempt_clean;
    logic          nack_pulse;

    assign fin_rise = i_init_finished & ~fin_q;

`ifdef CODEC_INIT_NACK_CHECK_EN
    i2c_ack_monitor u_ack_mon (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_sclk  (i_sclk),
        .i_sdat  (i_sdat),
        .i_oen   (i_oen),
        .o_nack  (nack_pulse)
    );

    assign attempt_clean = (nack_cnt_q == 8'd0);
`else
    // Bus copies are only observed when NACK checking is built in.
    logic unused_bus;
    assign unused_bus    = ^{i_sclk, i_sdat, i_oen};
    assign nack_pulse    = 1'b0;
    assign attempt_clean = 1'b1;
`endif

    // Next-state, counter and registered-output decode.
    always_comb begin
        state_d     = state_q;
        pwr_cnt_d   = pwr_cnt_q;
        timer_d     = timer_q;
        retry_cnt_d = retry_cnt_q;
        rst_ph_d    = rst_ph_q;
        fin_d       = i_init_finished;
        nack_cnt_d  = nack_cnt_q;

        case (state_q)
            S_POWERUP: begin
                if (pwr_cnt_q == PWR_LAST) begin
                    state_d = S_START;
                end else begin
                    pwr_cnt_d = pwr_cnt_q + PWR_ONE;
                end
            end
            S_START: begin
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (nack_pulse && (nack_cnt_q != NACK_CNT_MAX)) begin
                    nack_cnt_d = nack_cnt_q + 8'd1;
                end
                // Done wins over a simultaneous timeout.
                if (fin_rise) begin
                    if (attempt_clean) begin
                        state_d = S_READY;
                    end else begin
                        state_d     = S_RETRY;
                        retry_cnt_d = retry_cnt_q + RETRY_ONE;
                    end
                end else if (timer_q == TMR_LAST) begin
                    state_d     = S_RETRY;
                    retry_cnt_d = retry_cnt_q + RETRY_ONE;
                end else begin
                    timer_d = timer_q + TMR_ONE;
                end
            end
            S_RETRY: begin
                if (rst_ph_q) begin
                    rst_ph_d = 1'b0;
                    state_d  = (retry_cnt_q == RETRY_MAX) ? S_FAIL : S_START;
                end else begin
                    rst_ph_d = 1'b1;
                end
            end
            S_READY, S_FAIL: begin
                // Reinit restarts the retry budget; this reset phase is not a retry.
                if (i_reinit) begin
                    retry_cnt_d = '0;
                    state_d     = S_RETRY;
                end
            end
            default: begin
                state_d = S_POWERUP;
            end
        endcase

        // A fresh attempt starts with a clean timer and NACK tally.
        if (state_d == S_START) begin
            timer_d    = '0;
            nack_cnt_d = 8'd0;
        end

        start_d      = (state_d == S_START);
        init_rst_n_d = (state_d != S_RETRY);
        ready_d      = (state_d == S_READY);
        error_d      = (state_d == S_FAIL);
    end

    // State, counters and output registers.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q      <= S_POWERUP;
            pwr_cnt_q    <= '0;
            timer_q      <= '0;
            retry_cnt_q  <= '0;
            rst_ph_q     <= 1'b0;
            fin_q        <= 1'b0;
            nack_cnt_q   <= 8'd0;
            start_q      <= 1'b0;
            init_rst_n_q <= 1'b0;
            ready_q      <= 1'b0;
            error_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            pwr_cnt_q    <= pwr_cnt_d;
            timer_q      <= timer_d;
            retry_cnt_q  <= retry_cnt_d;
            rst_ph_q     <= rst_ph_d;
            fin_q        <= fin_d;
            nack_cnt_q   <= nack_cnt_d;
            start_q      <= start_d;
            init_rst_n_q <= init_rst_n_d;
            ready_q      <= ready_d;
            error_q      <= error_d;
        end
    end

    assign o_init_start = start_q;
    assign o_init_rst_n = init_rst_n_q;
    assign o_ready      = ready_q;
    assign o_error      = error_q;
    assign o_state      = state_q;
`ifdef CODEC_INIT_NACK_CHECK_EN
    assign o_nack_cnt   = nack_cnt_q;
`else
    assign o_nack_cnt   = 8'd0;
`endif

endmodule

// File: tb/tb_codec_init_ctrl.sv
// Bench for codec_init_ctrl: table-driven vectors with an expected-output queue.
// Latency: each vector holds its inputs for ncyc clocks, then outputs are sampled 1ns after the edge.
// Backpressure: n/a.
module tb_codec_init_ctrl;

    localparam logic [2:0] PU = 3'd0, ST = 3'd1, WT = 3'd2, RT = 3'd3, RD = 3'd4, FL = 3'd5;

`ifdef CODEC_INIT_NACK_CHECK_EN
    localparam logic [7:0] N1 = 8'd1, N2 = 8'd2, N3 = 8'd3;
`else
    localparam logic [7:0] N1 = 8'd0, N2 = 8'd0, N3 = 8'd0;
`endif

    logic       i_clk = 1'b0;
    logic       i_rst_n, i_reinit, i_init_finished, i_sclk, i_sdat, i_oen;
    logic       o_init_start, o_init_rst_n, o_ready, o_error;
    logic [7:0] o_nack_cnt;
    logic [2:0] o_state;

    always #5 i_clk = ~i_clk;

    codec_init_ctrl #(.POWERUP_CYCLES(8), .TIMEOUT_CYCLES(64), .MAX_RETRY(2)) dut (
        .i_clk           (i_clk),
        .i_rst_n         (i_rst_n),
        .i_reinit        (i_reinit),
        .i_init_finished (i_init_finished),
        .i_sclk          (i_sclk),
        .i_sdat          (i_sdat),
        .i_oen           (i_oen),
        .o_init_start    (o_init_start),
        .o_init_rst_n    (o_init_rst_n),
        .o_ready         (o_ready),
        .o_error         (o_error),
        .o_nack_cnt      (o_nack_cnt),
        .o_state         (o_state)
    );

    typedef struct packed {
        logic [2:0] st;
        logic       start;
        logic       rstn;
        logic       rdy;
        logic       err;
        logic [7:0] nack;
    } out_t;

    typedef struct {
        string name;
        logic  reinit, fin, sclk, sdat, oen;
        int    ncyc;
        out_t  exp;
    } vec_t;

    out_t exp_q[$];
    vec_t tbl[$];
    int   n_vec = 0;
    int   n_bad = 0;

    function automatic vec_t mkv(string nm, logic ri, logic fin, logic sc, logic sd, logic oe, int n,
                                 logic [2:0] st, logic sp, logic rn, logic rd, logic er, logic [7:0] nk);
        vec_t v;
        v.name = nm; v.reinit = ri; v.fin = fin; v.sclk = sc; v.sdat = sd; v.oen = oe; v.ncyc = n;
        v.exp.st = st; v.exp.start = sp; v.exp.rstn = rn; v.exp.rdy = rd; v.exp.err = er; v.exp.nack = nk;
        return v;
    endfunction

    // Drive a vector, queue its expectation, clock it, then compare.
    task automatic apply(input vec_t v);
        out_t got, e;
        i_reinit = v.reinit; i_init_finished = v.fin; i_sclk = v.sclk; i_sdat = v.sdat; i_oen = v.oen;
        exp_q.push_back(v.exp);
        for (int c = 0; c < v.ncyc; c++) begin
            @(posedge i_clk); #1;
            i_reinit = 1'b0;
        end
        i_reinit = 1'b0;
        got = {o_state, o_init_start, o_init_rst_n, o_ready, o_error, o_nack_cnt};
        e = exp_q.pop_front();
        n_vec++;
        if (got !== e) begin
            n_bad++;
            $display("FAIL %s: got st=%0d start=%b rstn=%b rdy=%b err=%b nack=%0d, required st=%0d start=%b rstn=%b rdy=%b err=%b nack=%0d",
                     v.name, got.st, got.start, got.rstn, got.rdy, got.err, got.nack,
                     e.st, e.start, e.rstn, e.rdy, e.err, e.nack);
        end
    endtask

    task automatic run_tbl();
        foreach (tbl[i]) apply(tbl[i]);
        tbl.delete();
    endtask

    // Count clocks after reset release until the start pulse shows (bounded).
    task automatic find_start(input string nm);
        int edges = 0;
        for (int e = 1; e <= 20; e++) begin
            @(posedge i_clk); #1;
            if (o_init_start) begin
                edges = e;
                break;
            end
        end
        n_vec++;
        if (edges != 8) begin
            n_bad++;
            $display("FAIL %s: start pulse after %0d clocks, required 8 (0 = never)", nm, edges);
        end
    endtask

    initial begin
        i_rst_n = 1'b0; i_reinit = 1'b0; i_init_finished = 1'b0; i_sclk = 1'b0; i_sdat = 1'b0; i_oen = 1'b1;
        repeat (3) @(posedge i_clk);
        #1;
        apply(mkv("reset_state", 0, 0, 0, 0, 1, 0, PU, 0, 0, 0, 0, 0));
        @(negedge i_clk);
        i_rst_n = 1'b1;
        apply(mkv("rstn_release", 0, 0, 0, 0, 1, 1, PU, 0, 1, 0, 0, 0));
        // find_start counts from release; one edge already consumed above
        tbl.push_back(mkv("pwr_hold", 0, 0, 0, 0, 1, 6, PU, 0, 1, 0, 0, 0));
        run_tbl();
        apply(mkv("start_pulse", 0, 0, 0, 0, 1, 1, ST, 1, 1, 0, 0, 0));

        // Normal attempt, reinit, timeouts to FAIL, reinit from FAIL, done vs timeout tie
        tbl.push_back(mkv("a_wait", 0, 0, 0, 0, 1, 1, WT, 0, 1, 0, 0, 0));
        for (int k = 0; k < 3; k++) begin
            tbl.push_back(mkv("a_ack_hi", 0, 0, 1, 0, 0, 1, WT, 0, 1, 0, 0, 0));
            tbl.push_back(mkv("a_ack_lo", 0, 0, 0, 0, 0, 1, WT, 0, 1, 0, 0, 0));
        end
        tbl.push_back(mkv("a_wait_hold",   0, 0, 0, 0, 1, 22, WT, 0, 1, 0, 0, 0));
        tbl.push_back(mkv("a_ready",       0, 1, 0, 0, 1, 1,  RD, 0, 1, 1, 0, 0));
        tbl.push_back(mkv("a_ready_hold",  0, 1, 0, 0, 1, 5,  RD, 0, 1, 1, 0, 0));
        tbl.push_back(mkv("a_reinit",      1, 1, 0, 0, 1, 1,  RT, 0, 0, 0, 0, 0));
        tbl.push_back(mkv("a_retry_2nd",   0, 0, 0, 0, 1, 1,  RT, 0, 0, 0, 0, 0));
        tbl.push_back(mkv("a_restart",     0, 0, 0, 0, 1, 1,  ST, 1, 1, 0, 0, 0));
        tbl.push_back(mkv("a_wait2",       0, 0, 0, 0, 1, 1,  WT, 0, 1, 0, 0, 0));
        tbl.push_back(mkv("a_reinit_wait", 1, 0, 0, 0, 1, 1,  WT, 0, 1, 0, 0, 0));
        tbl.push_back(mkv("a_to1_pre",     0, 0, 0, 0, 1, 62, WT, 0, 1, 0, 0, 0));
        tbl.push_back(mkv("a_to1",         0, 0, 0, 0, 1, 1,  RT, 0, 0, 0, 0, 0));
        tbl.push_back(mkv("a_to1_rst2",    0, 0, 0, 0, 1, 1,  RT, 0, 0, 0, 0, 0));
        tbl.push_back(mkv("a_start2",      0, 0, 0, 0, 1, 1,  ST, 1, 1, 0, 0, 0));
        tbl.push_back(mkv("a_wait3",       0, 0, 0, 0, 1, 1,  WT, 0, 1, 0, 0, 0));
        tbl.push_back(mkv("a_to2_pre",     0, 0, 0, 0, 1, 63, WT, 0, 1, 0, 0, 0));
        tbl.push_back(mkv("a_to2",         0, 0, 0, 0, 1, 1,  RT, 0, 0, 0, 0, 0));
        tbl.push_back(mkv("a_to2_rst2",    0, 0, 0, 0, 1, 1,  RT, 0, 0, 0, 0, 0));
        tbl.push_back(mkv("a_fail",        0, 0, 0, 0, 1, 1,  FL, 0, 1, 0, 1, 0));
        tbl.push_back(mkv("a_fail_hold",   0, 0, 0, 0, 1, 4,  FL, 0, 1, 0, 1, 0));
        tbl.push_back(mkv("a_reinit_fail", 1, 0, 0, 0, 1, 1,  RT, 0, 0, 0, 0, 0));
        tbl.push_back(mkv("a_rf_rst2",     0, 0, 0, 0, 1, 1,  RT, 0, 0, 0, 0, 0));
        tbl.push_back(mkv("a_retry_clr",   0, 0, 0, 0, 1, 1,  ST, 1, 1, 0, 0, 0));
        tbl.push_back(mkv("a_wait4",       0, 0, 0, 0, 1, 1,  WT, 0, 1, 0, 0, 0));
        tbl.push_back(mkv("a_tie_pre",     0, 0, 0, 0, 1, 63, WT, 0, 1, 0, 0, 0));
        tbl.push_back(mkv("a_tie_ready",   0, 1, 0, 0, 1, 1,  RD, 0, 1, 1, 0, 0));
        // Walk back into WAIT for the mid-attempt reset
        tbl.push_back(mkv("m_reinit",      1, 1, 0, 0, 1, 1,  RT, 0, 0, 0, 0, 0));
        tbl.push_back(mkv("m_rst2",        0, 0, 0, 0, 1, 1,  RT, 0, 0, 0, 0, 0));
        tbl.push_back(mkv("m_start",       0, 0, 0, 0, 1, 1,  ST, 1, 1, 0, 0, 0));
        tbl.push_back(mkv("m_wait",        0, 0, 0, 0, 1, 6,  WT, 0, 1, 0, 0, 0));
        run_tbl();

        // Asynchronous reset mid-attempt, then the power-up count restarts
        i_rst_n = 1'b0;
        #1;
        apply(mkv("rst_async",      0, 0, 0, 0, 1, 0, PU, 0, 0, 0, 0, 0));
        apply(mkv("rst_held",       0, 0, 0, 0, 1, 3, PU, 0, 0, 0, 0, 0));
        @(negedge i_clk);
        i_rst_n = 1'b1;
        find_start("start_after_rst");

        // NACK attempt: three qualified NACK edges plus non-qualifying edges
        tbl.push_back(mkv("n_wait",        0, 0, 0, 0, 1, 1, WT, 0, 1, 0, 0, 0));
        tbl.push_back(mkv("n_nack1",       0, 0, 1, 1, 0, 1, WT, 0, 1, 0, 0, N1));
        tbl.push_back(mkv("n_sclk_held",   0, 0, 1, 1, 0, 1, WT, 0, 1, 0, 0, N1));
        tbl.push_back(mkv("n_lo1",         0, 0, 0, 1, 0, 1, WT, 0, 1, 0, 0, N1));
        tbl.push_back(mkv("n_oen_high",    0, 0, 1, 1, 1, 1, WT, 0, 1, 0, 0, N1));
        tbl.push_back(mkv("n_lo2",         0, 0, 0, 1, 0, 1, WT, 0, 1, 0, 0, N1));
        tbl.push_back(mkv("n_ack_ok",      0, 0, 1, 0, 0, 1, WT, 0, 1, 0, 0, N1));
        tbl.push_back(mkv("n_lo3",         0, 0, 0, 0, 0, 1, WT, 0, 1, 0, 0, N1));
        tbl.push_back(mkv("n_nack2",       0, 0, 1, 1, 0, 1, WT, 0, 1, 0, 0, N2));
        tbl.push_back(mkv("n_lo4",         0, 0, 0, 1, 0, 1, WT, 0, 1, 0, 0, N2));
        tbl.push_back(mkv("n_nack3",       0, 0, 1, 1, 0, 1, WT, 0, 1, 0, 0, N3));
        tbl.push_back(mkv("n_lo5",         0, 0, 0, 0, 1, 1, WT, 0, 1, 0, 0, N3));
`ifdef CODEC_INIT_NACK_CHECK_EN
        tbl.push_back(mkv("n_done_retry",  0, 1, 0, 0, 1, 1, RT, 0, 0, 0, 0, 8'd3));
        tbl.push_back(mkv("n_retry_2nd",   0, 0, 0, 0, 1, 1, RT, 0, 0, 0, 0, 8'd3));
        tbl.push_back(mkv("n_restart",     0, 0, 0, 0, 1, 1, ST, 1, 1, 0, 0, 0));
        tbl.push_back(mkv("n_wait2",       0, 0, 0, 0, 1, 1, WT, 0, 1, 0, 0, 0));
        tbl.push_back(mkv("n_clean_ack",   0, 0, 1, 0, 0, 1, WT, 0, 1, 0, 0, 0));
        tbl.push_back(mkv("n_clean_lo",    0, 0, 0, 0, 0, 1, WT, 0, 1, 0, 0, 0));
        tbl.push_back(mkv("n_ready",       0, 1, 0, 0, 1, 1, RD, 0, 1, 1, 0, 0));
`else
        tbl.push_back(mkv("n_ready",       0, 1, 0, 0, 1, 1, RD, 0, 1, 1, 0, 0));
`endif
        tbl.push_back(mkv("n_ready_hold",  0, 1, 0, 0, 1, 3, RD, 0, 1, 1, 0, 0));
        run_tbl();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/codec_init_ctrl.md
CODEC_INIT_CTRL -- requirements
Module: codec_init_ctrl

Interface
REQ-001 SHALL have parameter POWERUP_CYCLES, default 1000, meaning idle cycles after reset before the first attempt.
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 200000, meaning the maximum cycles one attempt may last.
REQ-003 SHALL have parameter MAX_RETRY, default 3, meaning the number of failed attempts before permanent failure.
REQ-004 SHALL have port i_clk  input  1  clock.
REQ-005 SHALL have port i_rst_n  input  1  reset; asynchronous, active-low.
REQ-006 SHALL have port i_reinit  input  1  one-cycle request to redo the codec init.
REQ-007 SHALL have port i_init_finished  input  1  level done flag from the I2C initializer.
REQ-008 SHALL have ports i_sclk, i_sdat and i_oen, each input  1, meaning a copy of the I2C bus clock, the bus data and the initializer output-enable.
REQ-009 SHALL have port o_init_start  output  1  one-cycle start pulse to the initializer.
REQ-010 SHALL have port o_init_rst_n  output  1  active-low reset to the initializer.
REQ-011 SHALL have ports o_ready and o_error, each output  1, meaning the codec is configured and init has failed permanently.
REQ-012 SHALL have port o_nack_cnt  output  8  NACKs seen in the last attempt.
REQ-013 SHALL have port o_state  output  3  current state code.

Function
REQ-014 The FSM states SHALL be S_POWERUP=0, S_START=1, S_WAIT=2, S_RETRY=3, S_READY=4, S_FAIL=5.
REQ-015 S_POWERUP SHALL count POWERUP_CYCLES cycles, then go to S_START.
REQ-016 S_START SHALL drive o_init_start=1 for exactly one cycle, clear the attempt timer and o_nack_cnt, and go to S_WAIT.
REQ-017 S_WAIT SHALL detect the rising edge of i_init_finished using a registered copy; i_init_finished already high on entry SHALL NOT count.
REQ-018 On that edge, S_WAIT SHALL go to S_READY if o_nack_cnt==0, else to S_RETRY.
REQ-019 S_WAIT SHALL go to S_RETRY when the timer reaches TIMEOUT_CYCLES-1.
REQ-020 A finished edge and a timeout in the same cycle SHALL resolve as a finished edge.
REQ-021 S_RETRY SHALL drive o_init_rst_n=0 for exactly 2 cycles and increment the 2-bit-minimum retry counter.
REQ-022 After those 2 cycles, S_RETRY SHALL go to S_FAIL when the counter equals MAX_RETRY, else to S_START.
REQ-023 A NACK SHALL be a rising i_sclk edge (registered i_sclk==0, current i_sclk==1) while i_oen==0 and i_sdat==1.
REQ-024 o_nack_cnt SHALL saturate at 255.
REQ-025 S_READY SHALL hold o_ready=1, and S_FAIL SHALL hold o_error=1; both are registered outputs.
REQ-026 i_reinit in S_READY or S_FAIL SHALL clear the retry counter, drop o_ready/o_error next cycle, and enter S_RETRY without counting that entry as a retry.
REQ-027 i_reinit SHALL be ignored in all other states.
REQ-028 All counters SHALL be sized with $clog2 of their parameter, with no wrap-around within their range.

Reset
REQ-029 Asserting i_rst_n SHALL, at any time including mid-attempt, give: state S_POWERUP, o_init_start=0, o_init_rst_n=0, o_ready=0, o_error=0, o_nack_cnt=0, all counters 0, edge registers 0.
REQ-030 o_init_rst_n SHALL go to 1 on the first clock after i_rst_n deasserts.

Configuration
REQ-031 With CODEC_INIT_NACK_CHECK_EN defined, NACK detection SHALL behave as REQ-018, REQ-023 and REQ-024.
REQ-032 Without CODEC_INIT_NACK_CHECK_EN, i_sdat, i_sclk and i_oen SHALL be unused, o_nack_cnt SHALL be tied to 0, and every finished edge SHALL go to S_READY.

Structure
REQ-033 Package codec_init_pkg SHALL hold the state enum (3-bit) and the default parameter constants.
REQ-034 Sub-module i2c_ack_monitor SHALL hold the sclk edge detect and NACK qualification and output a one-cycle nack pulse; it SHALL be instantiated only under CODEC_INIT_NACK_CHECK_EN.

Verification
REQ-035 Bench parameters SHALL be POWERUP_CYCLES=8, TIMEOUT_CYCLES=64, MAX_RETRY=2.
REQ-036 Normal case: reset, then model raises i_init_finished 30 cycles after start with sdat=0 at every ack -> o_init_start pulses once at cycle 9 after reset release; o_ready=1, o_error=0, o_nack_cnt=0.
REQ-037 Timeout case: i_init_finished never rises -> two attempts each end after 64 WAIT cycles with a 2-cycle o_init_rst_n low; then o_error=1 and o_state=5.
REQ-038 NACK case: first attempt has sdat=1 on 3 ack rising edges, second attempt is clean -> after the first attempt o_nack_cnt=3 and a retry starts; after the second, o_ready=1 and o_nack_cnt=0.
REQ-039 Edge case: finished edge and timer==63 in the same cycle -> state goes to S_READY.
REQ-040 Reinit case: i_reinit pulse in S_READY -> o_ready=0 next cycle, o_init_rst_n low 2 cycles, new start pulse, retry counter=0; i_reinit pulsed in S_WAIT -> no effect.
REQ-041 Reset mid-attempt: i_rst_n asserted in S_WAIT -> all outputs take REQ-029 values immediately (asynchronously), then the power-up count restarts from 0.
